if_inst_resp: RTL and testbench
===============================

IF_INST_RESP -- requirements
Module: if_inst_resp

Interface
REQ-001 Parameter DATA_W, default 64, width of one fetch response (two 32-bit instructions) and buffer width.
REQ-002 Parameter MAX_OUTST, default 2, maximum in-flight instruction-SRAM requests; counter width is clog2(MAX_OUTST+1).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-high (asserted = 1).
REQ-005 inst_req_fire_i  input  1  a request was accepted this cycle (req & addr_ok).
REQ-006 inst_data_ok_i  input  1  a response beat is present on inst_rdata_i.
REQ-007 inst_rdata_i  input  DATA_W  response data.
REQ-008 excep_flush_i  input  1  exception flush.
REQ-009 banch_flush_i  input  1  branch flush.
REQ-010 if_valid_i  input  1  IF stage holds a fetch awaiting its data.
REQ-011 id_allowin_i  input  1  ID stage accepts this cycle.
REQ-012 if_ready_go_o  output  1  IF data available for ID.
REQ-013 inst_o  output  DATA_W  instruction data to ID.
REQ-014 outst_cnt_o  output  clog2(MAX_OUTST+1)  in-flight request count.
REQ-015 inst_rdata_ce_o  output  1  high while at least one returning response must be discarded.
REQ-016 err_o  output  1  sticky protocol-violation flag.

Function
REQ-017 outst_cnt increments on inst_req_fire_i, decrements on inst_data_ok_i, unchanged when both are high.
REQ-018 inst_req_fire_i with outst_cnt == MAX_OUTST, or inst_data_ok_i with outst_cnt == 0, leaves the counter saturated and sets err_o.
REQ-019 On a flush (excep_flush_i | banch_flush_i), cancel_cnt loads outst_cnt minus inst_data_ok_i of the same cycle; buffered data is invalidated.
REQ-020 inst_data_ok_i while cancel_cnt > 0 discards the beat and decrements cancel_cnt; inst_rdata_ce_o = (cancel_cnt != 0).
REQ-021 A flush arriving while cancel_cnt > 0 reloads cancel_cnt per REQ-019; it never accumulates beyond outst_cnt.
REQ-022 Buffer FSM states: EMPTY, FULL.
REQ-023 EMPTY->FULL on a non-discarded data_ok when not (if_valid_i & id_allowin_i), or on any non-discarded data_ok when the bypass is compiled out.
REQ-024 FULL->EMPTY when if_valid_i & id_allowin_i, or on a flush; flush has priority over capture.
REQ-025 In FULL, if_ready_go_o = if_valid_i and inst_o = buffer; in EMPTY, if_ready_go_o = bypass hit (REQ-031) and otherwise 0.
REQ-026 A data_ok arriving in FULL while the buffer is not drained in the same cycle is a violation: err_o sets and the new beat is dropped.
REQ-027 inst_o is 0 whenever if_ready_go_o is 0.

Reset
REQ-028 On reset: outst_cnt = 0, cancel_cnt = 0, FSM = EMPTY, buffer = 0, err_o = 0, if_ready_go_o = 0, inst_o = 0.
REQ-029 Reset in the middle of outstanding traffic drops all counts; responses after reset count as violations (err_o).
REQ-030 Reset has priority over flush and all other events.

Configuration
REQ-031 Macro IF_RESP_BYPASS_EN defined: a non-discarded data_ok with FSM EMPTY and if_valid_i drives if_ready_go_o = 1 and inst_o = inst_rdata_i in the same cycle (0-cycle latency).
REQ-032 Macro undefined: every response is captured into the buffer first; the earliest if_ready_go_o is one cycle after data_ok.

Structure
REQ-033 FSM state encodings and DATA_W/MAX_OUTST defaults live in the shared pipeline-bus package/header alongside the existing stage bus widths.
REQ-034 The outstanding/cancel counter pair is one sub-module, if_resp_cnt; the buffer FSM stays in the top module.

Verification
REQ-035 Bypass build: fire at t0, data_ok 0x1C000004_1C000000 at t2 with if_valid_i = 1 and id_allowin_i = 1 -> if_ready_go_o = 1 and inst_o equal to that value at t2; outst_cnt returns to 0.
REQ-036 Two fires, banch_flush_i next cycle, two data_ok -> inst_rdata_ce_o = 1 for both beats, if_ready_go_o stays 0, cancel_cnt ends at 0.
REQ-037 data_ok with id_allowin_i = 0 -> FSM FULL; id_allowin_i = 1 three cycles later -> inst_o equals the captured data, FSM EMPTY next cycle.
REQ-038 Flush in the same cycle as data_ok with outst_cnt = 2 -> cancel_cnt = 1, the current beat is not delivered, and the next beat is discarded.
REQ-039 A third fire with MAX_OUTST = 2 -> err_o = 1 sticky, outst_cnt stays 2; rst_n = 1 for one cycle clears err_o and all counts.
REQ-040 Non-bypass build, same stimulus as REQ-035 -> if_ready_go_o rises at t3, not t2.

Source files
------------

// File: rtl/if_inst_resp_pkg.sv
// Shared pipeline-bus definitions for the IF stage: stage bus widths, fetch
// response defaults and the IF response-buffer state encodings.
package if_inst_resp_pkg;

    localparam int FS_TO_DS_BUS_WD = 96;
    localparam int DS_TO_ES_BUS_WD = 160;
    localparam int BR_BUS_WD       = 33;

    localparam int IF_DATA_W    = 64;
    localparam int IF_MAX_OUTST = 2;

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

endpackage

// File: rtl/if_inst_resp_cnt.sv
// Outstanding-request and cancel counters for the IF response path; also
// decides which returning beats are stale and must be discarded.
module if_resp_cnt
    import if_inst_resp_pkg::*;
#(
    parameter int MAX_OUTST = IF_MAX_OUTST,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fire_i,
    input  logic             data_ok_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] outst_cnt_o,
    output logic             cancel_active_o,
    output logic             discard_o,
    output logic             viol_o
);

    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] cancel_q, cancel_d;
    logic             incr, decr;

    assign incr = fire_i & ~data_ok_i;
    assign decr = data_ok_i & ~fire_i;

    // Fire and response together cancel out, so only a net change can
    // overflow or underflow the counter.
    always_comb begin
        outst_d  = outst_q;
        cancel_d = cancel_q;
        viol_o   = 1'b0;
        if (incr) begin
            if (outst_q == CNT_W'(MAX_OUTST)) viol_o = 1'b1;
            else                              outst_d = outst_q + CNT_W'(1);
        end
        if (decr) begin
            if (outst_q == '0) viol_o = 1'b1;
            else               outst_d = outst_q - CNT_W'(1);
        end
        if (flush_i) begin
            cancel_d = (data_ok_i && outst_q != '0) ? outst_q - CNT_W'(1) : outst_q;
        end else if (data_ok_i && cancel_q != '0) begin
            cancel_d = cancel_q - CNT_W'(1);
        end
    end

    // A beat with nothing outstanding is stray and is dropped as well.
    assign discard_o = data_ok_i &
                       (flush_i | (cancel_q != '0) | ((outst_q == '0) & ~fire_i));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            outst_q  <= '0;
            cancel_q <= '0;
        end else begin
            outst_q  <= outst_d;
            cancel_q <= cancel_d;
        end
    end

    assign outst_cnt_o     = outst_q;
    assign cancel_active_o = (cancel_q != '0);

endmodule

// File: rtl/if_inst_resp.sv
// IF-stage instruction response handler: one-entry response buffer with
// flush cancellation. Define IF_RESP_BYPASS_EN for 0-cycle bypass to ID.
module if_inst_resp
    import if_inst_resp_pkg::*;
#(
    parameter int DATA_W    = IF_DATA_W,
    parameter int MAX_OUTST = IF_MAX_OUTST
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               inst_req_fire_i,
    input  logic                               inst_data_ok_i,
    input  logic [DATA_W-1:0]                  inst_rdata_i,
    input  logic                               excep_flush_i,
    input  logic                               banch_flush_i,
    input  logic                               if_valid_i,
    input  logic                               id_allowin_i,
    output logic                               if_ready_go_o,
    output logic [DATA_W-1:0]                  inst_o,
    output logic [$clog2(MAX_OUTST+1)-1:0]     outst_cnt_o,
    output logic                               inst_rdata_ce_o,
    output logic                               err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic              flush, accept, drain, discard, cnt_viol, fsm_viol, bypass_hit;
    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              err_q, err_d;

    if_resp_cnt #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk             (clk),
        .rst_n           (rst_n),
        .fire_i          (inst_req_fire_i),
        .data_ok_i       (inst_data_ok_i),
        .flush_i         (flush),
        .outst_cnt_o     (outst_cnt_o),
        .cancel_active_o (inst_rdata_ce_o),
        .discard_o       (discard),
        .viol_o          (cnt_viol)
    );

    assign flush  = excep_flush_i | banch_flush_i;
    assign accept = inst_data_ok_i & ~discard;
    assign drain  = if_valid_i & id_allowin_i;

    // A beat landing while FULL is drained the same cycle refills the buffer
    // rather than being lost.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        fsm_viol = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
            buf_d   = '0;
        end else if (state_q == S_EMPTY) begin
`ifdef IF_RESP_BYPASS_EN
            if (accept && !drain) begin
`else
            if (accept) begin
`endif
                state_d = S_FULL;
                buf_d   = inst_rdata_i;
            end
        end else begin
            if (drain) begin
                if (accept) buf_d   = inst_rdata_i;
                else        state_d = S_EMPTY;
            end else if (accept) begin
                fsm_viol = 1'b1;
            end
        end
    end

`ifdef IF_RESP_BYPASS_EN
    assign bypass_hit = (state_q == S_EMPTY) & accept & if_valid_i;
`else
    assign bypass_hit = 1'b0;
`endif

    assign err_d = err_q | cnt_viol | fsm_viol;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_EMPTY;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    assign if_ready_go_o = ~rst_n & (((state_q == S_FULL) & if_valid_i) | bypass_hit);
    assign inst_o        = !if_ready_go_o     ? '0    :
                           (state_q == S_FULL) ? buf_q : inst_rdata_i;
    assign err_o         = err_q;

endmodule

// File: tb/tb_if_inst_resp.sv
// Self-checking bench for if_inst_resp: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_if_inst_resp;

`ifdef IF_RESP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fire, ok, ef, bf, valid, allowin;
    logic [63:0] rdata;
    logic        readyGo, ce, err;
    logic [63:0] instOut;
    logic [1:0]  outst;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit checkEn = 1'b0;

    // Reference model: one entry per in-flight request, 1 = cancelled by a flush.
    bit          pend[$];
    bit          mFull = 1'b0;
    logic [63:0] mBuf  = '0;
    bit          mErr  = 1'b0;

    if_inst_resp dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_req_fire_i (fire),
        .inst_data_ok_i  (ok),
        .inst_rdata_i    (rdata),
        .excep_flush_i   (ef),
        .banch_flush_i   (bf),
        .if_valid_i      (valid),
        .id_allowin_i    (allowin),
        .if_ready_go_o   (readyGo),
        .inst_o          (instOut),
        .outst_cnt_o     (outst),
        .inst_rdata_ce_o (ce),
        .err_o           (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit f, input bit k, input logic [63:0] d,
                                 input bit e, input bit b, input bit v, input bit a);
        @(posedge clk);
        #1;
        fire = f; ok = k; rdata = d; ef = e; bf = b; valid = v; allowin = a;
    endtask

    // Compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        bit          flushNow, frontCancel, under, over, disc, acc, drn, expReady;
        logic [63:0] expInst;
        int          nCancel;
        flushNow    = ef | bf;
        frontCancel = (pend.size() > 0) && pend[0];
        under       = ok && !fire && pend.size() == 0;
        over        = fire && !ok && pend.size() == MAXO;
        disc        = ok && (flushNow || frontCancel || under);
        acc         = ok && !disc;
        drn         = valid && allowin;
        nCancel     = 0;
        foreach (pend[i]) if (pend[i]) nCancel++;
        expReady = rst_n ? 1'b0 : (mFull ? valid : (BYPASS && acc && valid));
        expInst  = !expReady ? 64'd0 : (mFull ? mBuf : rdata);
        if (checkEn) begin
            checkOutput("ready_go",  {63'd0, readyGo}, {63'd0, expReady});
            checkOutput("inst",      instOut, expInst);
            checkOutput("outst_cnt", {62'd0, outst}, 64'(pend.size()));
            checkOutput("rdata_ce",  {63'd0, ce}, {63'd0, nCancel > 0});
            checkOutput("err",       {63'd0, err}, {63'd0, mErr});
        end
        if (rst_n) begin
            pend.delete();
            mFull = 1'b0; mBuf = '0; mErr = 1'b0;
        end else begin
            if (over || under || (mFull && acc && !drn)) mErr = 1'b1;
            if (!(ok && fire && pend.size() == 0)) begin
                if (ok && pend.size() > 0) void'(pend.pop_front());
                if (flushNow) foreach (pend[i]) pend[i] = 1'b1;
                if (fire && !over) pend.push_back(1'b0);
            end
            if (flushNow) begin
                mFull = 1'b0; mBuf = '0;
            end else if (mFull) begin
                if (drn) begin
                    if (acc) mBuf = rdata;
                    else     mFull = 1'b0;
                end
            end else if (acc && !(BYPASS && drn)) begin
                mFull = 1'b1; mBuf = rdata;
            end
        end
    end

    initial begin
        logic [63:0] d0, d1;
        d0 = 64'h1C000004_1C000000;
        d1 = 64'hDEADBEEF_00C0FFEE;
        rst_n = 1'b1;
        fire = 0; ok = 0; rdata = '0; ef = 0; bf = 0; valid = 0; allowin = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset_outst", {62'd0, outst}, 64'd0);
        checkOutput("reset_err",   {63'd0, err}, 64'd0);
        checkOutput("reset_ce",    {63'd0, ce}, 64'd0);
        checkOutput("reset_ready", {63'd0, readyGo}, 64'd0);

        // Single fetch, response at t2 with ID ready.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, d0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t2_ready", {63'd0, readyGo}, {63'd0, BYPASS});
        checkOutput("t2_inst",  instOut, BYPASS ? d0 : 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t3_ready", {63'd0, readyGo}, {63'd0, !BYPASS});
        checkOutput("t3_inst",  instOut, BYPASS ? 64'd0 : d0);
        checkOutput("t3_outst", {62'd0, outst}, 64'd0);

        // Two fires, branch flush, both returning beats discarded.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, d1, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("flush_b1_ce",    {63'd0, ce}, 64'd1);
        checkOutput("flush_b1_ready", {63'd0, readyGo}, 64'd0);
        applyStimulus(0, 1, d0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("flush_b2_ce",    {63'd0, ce}, 64'd1);
        checkOutput("flush_b2_ready", {63'd0, readyGo}, 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("flush_end_ce",    {63'd0, ce}, 64'd0);
        checkOutput("flush_end_ready", {63'd0, readyGo}, 64'd0);

        // ID stalls: capture, hold three cycles, then drain.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, d1, 0, 0, 1, 0);
        repeat (3) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            checkOutput("hold_inst", instOut, d1);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("drain_inst", instOut, d1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("drained_ready", {63'd0, readyGo}, 64'd0);

        // Flush coinciding with a beat at two outstanding.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, d0, 1, 0, 1, 1);
        @(negedge clk);
        checkOutput("flushok_ready", {63'd0, readyGo}, 64'd0);
        applyStimulus(0, 1, d1, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("flushok_ce",    {63'd0, ce}, 64'd1);
        checkOutput("flushok_outst", {62'd0, outst}, 64'd1);
        checkOutput("flushok_ready", {63'd0, readyGo}, 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("flushok_end_ce", {63'd0, ce}, 64'd0);

        // Overflow, sticky error, reset recovery, stray beat after reset.
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("ovf_err",   {63'd0, err}, 64'd1);
        checkOutput("ovf_outst", {62'd0, outst}, 64'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("ovf_sticky", {63'd0, err}, 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_err",   {63'd0, err}, 64'd0);
        checkOutput("rst_outst", {62'd0, outst}, 64'd0);
        applyStimulus(0, 1, d0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("stray_ready", {63'd0, readyGo}, 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("stray_err", {63'd0, err}, 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            rst_n   = ($urandom_range(0, 199) == 0);
            fire    = ($urandom_range(0, 9) < 4);
            ok      = (pend.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            rdata   = {$urandom, $urandom};
            ef      = ($urandom_range(0, 59) == 0);
            bf      = ($urandom_range(0, 29) == 0);
            valid   = ($urandom_range(0, 9) < 8);
            allowin = ($urandom_range(0, 9) < 7);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
